// File: rtl/bridge_rom_loader.sv
// Bridge-to-ROM loader: buffers big-endian bridge words in a FIFO and
// serialises them into byte writes with ready backpressure.
module bridge_rom_loader #(
  parameter int unsigned ROM_BYTES  = 32'h00100000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        bridge_wr,
  input  logic        bridge_rd,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  output logic [31:0] bridge_rd_data,
  output logic        rom_wr,
  input  logic        rom_ready,
  output logic [19:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        busy,
  output logic        overflow,
  output logic        range_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PONE = 1;
  localparam logic [31:0] CLR_ADDR = ROM_BYTES - 32'd4;

  typedef enum logic {IDLE, SEND} state_t;

  logic [49:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, nptr;
  logic        empty, full, has_next;
  logic        is_clr, in_range, push;
  logic        accept, retire, load;
  logic [49:0] load_word;

  state_t      state_q;
  logic [1:0]  idx_q, idx_n;
  logic [49:0] word_q;
  logic [20:0] cnt_q;
  logic        ovf_q, rerr_q, rom_wr_q;
  logic [19:0] rom_addr_q;
  logic [7:0]  rom_data_q;
  logic [31:0] rd_q;

  function automatic logic [7:0] bsel(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    unique case (i)
      2'd0:    bsel = w[31:24];
      2'd1:    bsel = w[23:16];
      2'd2:    bsel = w[15:8];
      default: bsel = w[7:0];
    endcase
  endfunction

  assign empty    = wptr_q == rptr_q;
  assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign nptr     = rptr_q + PONE;
  assign has_next = nptr != wptr_q;

  // The word being sent stays in the FIFO until its last byte is taken
  assign accept   = rom_wr_q & rom_ready;
  assign retire   = accept && (idx_q == 2'd3);
  assign load     = ((state_q == IDLE) && !empty) || (retire && has_next);
  assign load_word = retire ? mem_q[nptr[AW-1:0]]
                            : mem_q[rptr_q[AW-1:0]];
  assign idx_n    = idx_q + 2'd1;

  assign is_clr   = bridge_wr && (bridge_addr == CLR_ADDR) &&
                    (bridge_wr_data == 32'hFFFFFFFF);
  assign in_range = bridge_addr < ROM_BYTES;
  assign push     = bridge_wr && !is_clr && in_range &&
                    (!full || retire);

  always_ff @(posedge clk_74a) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {bridge_addr[19:2], bridge_wr_data};
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      rerr_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      if (push)   wptr_q <= wptr_q + PONE;
      if (retire) rptr_q <= nptr;
      if (is_clr) begin
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        rerr_q <= 1'b0;
      end else begin
        if (accept && (cnt_q != '1)) cnt_q <= cnt_q + 21'd1;
        if (bridge_wr && in_range && full && !retire) ovf_q <= 1'b1;
        if (bridge_wr && !in_range) rerr_q <= 1'b1;
      end
      if (bridge_rd) rd_q <= {busy, ovf_q, rerr_q, 8'd0, cnt_q};
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      word_q     <= '0;
      rom_wr_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
    end else if (load) begin
      state_q    <= SEND;
      idx_q      <= 2'd0;
      word_q     <= load_word;
      rom_wr_q   <= 1'b1;
      rom_addr_q <= {load_word[49:32], 2'd0};
      rom_data_q <= load_word[31:24];
    end else if (accept) begin
      if (idx_q == 2'd3) begin
        state_q  <= IDLE;
        rom_wr_q <= 1'b0;
      end else begin
        idx_q      <= idx_n;
        rom_addr_q <= {word_q[49:32], idx_n};
        rom_data_q <= bsel(word_q[31:0], idx_n);
      end
    end
  end

  assign busy           = !empty || (state_q == SEND);
  assign overflow       = ovf_q;
  assign range_err      = rerr_q;
  assign bridge_rd_data = rd_q;
  assign rom_wr         = rom_wr_q;
  assign rom_addr       = rom_addr_q;
  assign rom_data       = rom_data_q;

endmodule

// File: tb/tb_bridge_rom_loader.sv
// Directed bench for bridge_rom_loader: byte ordering, backpressure,
// overflow, range, clear and mid-word reset.
module tb_bridge_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bridge_wr, bridge_rd;
  logic [31:0] bridge_addr, bridge_wr_data, bridge_rd_data;
  logic        rom_wr, rom_ready;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy, overflow, range_err;

  int checks = 0;
  int errors = 0;
  logic [27:0] log_q[$];

  bridge_rom_loader dut (
    .clk_74a       (clk),
    .reset_n       (reset_n),
    .bridge_wr     (bridge_wr),
    .bridge_rd     (bridge_rd),
    .bridge_addr   (bridge_addr),
    .bridge_wr_data(bridge_wr_data),
    .bridge_rd_data(bridge_rd_data),
    .rom_wr        (rom_wr),
    .rom_ready     (rom_ready),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .busy          (busy),
    .overflow      (overflow),
    .range_err     (range_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_wr && rom_ready) log_q.push_back({rom_addr, rom_data});
  end

  task automatic bwrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bridge_wr = 1'b1;
    bridge_addr = a;
    bridge_wr_data = d;
    @(negedge clk);
    bridge_wr = 1'b0;
  endtask

  task automatic bread(output logic [31:0] v);
    @(negedge clk);
    bridge_rd = 1'b1;
    @(negedge clk);
    bridge_rd = 1'b0;
    v = bridge_rd_data;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_wr(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rom_wr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] got;
    #3;
    got = {rom_wr, |rom_addr, |rom_data, busy, overflow, range_err,
           |bridge_rd_data, 1'b0};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000000", got);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rom_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b rom_wr=%b want 0 0", busy, rom_wr);
    end
  endtask

  task automatic test_single;
    int base;
    bit ok;
    logic [27:0] exp [4];
    logic [31:0] st;
    exp[0] = {20'h00100, 8'hA1};
    exp[1] = {20'h00101, 8'hB2};
    exp[2] = {20'h00102, 8'hC3};
    exp[3] = {20'h00103, 8'hD4};
    rom_ready = 1'b1;
    base = log_q.size();
    bwrite(32'h100, 32'hA1B2C3D4);
    wait_idle(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout busy=%b want 0", busy);
    end
    checks++;
    if (log_q.size() - base !== 4) begin
      errors++;
      $display("FAIL single_count got=%0d want=4", log_q.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (base + i >= log_q.size() || log_q[base+i] !== exp[i]) begin
        errors++;
        $display("FAIL single_byte%0d got=%h want=%h", i,
                 (base + i < log_q.size()) ? log_q[base+i] : 28'hx, exp[i]);
      end
    end
    bread(st);
    checks++;
    if (st !== 32'h00000004) begin
      errors++;
      $display("FAIL single_status got=%h want=00000004", st);
    end
  endtask

  task automatic test_backpressure;
    int base;
    bit ok;
    rom_ready = 1'b0;
    base = log_q.size();
    bwrite(32'h100, 32'hA1B2C3D4);
    wait_wr(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_start rom_wr=%b want 1", rom_wr);
    end
    rom_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rom_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rom_wr !== 1'b1 || rom_addr !== 20'h00102 || rom_data !== 8'hC3) begin
        errors++;
        $display("FAIL bp_hold%0d wr=%b addr=%h data=%h want 1 00102 c3",
                 i, rom_wr, rom_addr, rom_data);
      end
      @(negedge clk);
    end
    rom_ready = 1'b1;
    wait_idle(20, ok);
    checks++;
    if (!ok || log_q.size() - base !== 4) begin
      errors++;
      $display("FAIL bp_count got=%0d want=4", log_q.size() - base);
    end
    checks++;
    if (log_q[base+2] !== {20'h00102, 8'hC3} ||
        log_q[base+3] !== {20'h00103, 8'hD4}) begin
      errors++;
      $display("FAIL bp_bytes got=%h,%h want=00102c3,00103d4",
               log_q[base+2], log_q[base+3]);
    end
  endtask

  task automatic test_overflow;
    int base;
    logic [7:0] b;
    rom_ready = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b = 8'h10 + 8'(4 * i);
      bridge_wr = 1'b1;
      bridge_addr = 32'h1000 + 32'(4 * i);
      bridge_wr_data = {b, b + 8'd1, b + 8'd2, b + 8'd3};
    end
    @(negedge clk);
    bridge_wr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag overflow=%b busy=%b want 1 1", overflow, busy);
    end
    checks++;
    if (log_q.size() != base) begin
      errors++;
      $display("FAIL ovf_stall got=%0d bytes want=0", log_q.size() - base);
    end
    rom_ready = 1'b1;
    repeat (16) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || log_q.size() - base !== 16) begin
      errors++;
      $display("FAIL ovf_drain busy=%b bytes=%0d want 0 16",
               busy, log_q.size() - base);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (base + k >= log_q.size() ||
          log_q[base+k] !== {20'h01000 + 20'(k), 8'h10 + 8'(k)}) begin
        errors++;
        $display("FAIL ovf_byte%0d got=%h want=%h", k,
                 (base + k < log_q.size()) ? log_q[base+k] : 28'hx,
                 {20'h01000 + 20'(k), 8'h10 + 8'(k)});
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (log_q.size() - base !== 16) begin
      errors++;
      $display("FAIL ovf_extra got=%0d bytes want=16", log_q.size() - base);
    end
  endtask

  task automatic test_range;
    int base;
    logic [31:0] st;
    rom_ready = 1'b1;
    base = log_q.size();
    bwrite(32'h00100000, 32'h55667788);
    repeat (8) @(negedge clk);
    checks++;
    if (log_q.size() != base || range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_drop bytes=%0d range_err=%b want 0 1",
               log_q.size() - base, range_err);
    end
    bread(st);
    checks++;
    if (st !== 32'h60000018) begin
      errors++;
      $display("FAIL range_status got=%h want=60000018", st);
    end
  endtask

  task automatic test_clear;
    int base;
    logic [31:0] st;
    base = log_q.size();
    bwrite(32'h000FFFFC, 32'hFFFFFFFF);
    checks++;
    if (overflow !== 1'b0 || range_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags ovf=%b rerr=%b busy=%b want 0 0 0",
               overflow, range_err, busy);
    end
    repeat (6) @(negedge clk);
    bread(st);
    checks++;
    if (st !== 32'h00000000 || log_q.size() != base) begin
      errors++;
      $display("FAIL clear_status got=%h bytes=%0d want=00000000 0",
               st, log_q.size() - base);
    end
  endtask

  task automatic test_reset_midword;
    int base;
    bit ok;
    logic [31:0] st;
    logic [7:0] got;
    rom_ready = 1'b0;
    bwrite(32'h300, 32'h01020304);
    bwrite(32'h304, 32'h05060708);
    wait_wr(10, ok);
    rom_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rom_ready = 1'b0;
    bread(st);
    checks++;
    if (!ok || st !== 32'h80000002 || rom_addr !== 20'h00302) begin
      errors++;
      $display("FAIL mid_setup status=%h addr=%h want=80000002 00302",
               st, rom_addr);
    end
    reset_n = 1'b0;
    #1;
    got = {rom_wr, |rom_addr, |rom_data, busy, overflow, range_err,
           |bridge_rd_data, 1'b0};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL mid_async got=%b want=00000000", got);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rom_ready = 1'b1;
    base = log_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != base || busy !== 1'b0 || rom_wr !== 1'b0) begin
      errors++;
      $display("FAIL mid_after bytes=%0d busy=%b wr=%b want 0 0 0",
               log_q.size() - base, busy, rom_wr);
    end
    bread(st);
    checks++;
    if (st !== 32'h00000000) begin
      errors++;
      $display("FAIL mid_status got=%h want=00000000", st);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bridge_wr = 1'b0;
    bridge_rd = 1'b0;
    bridge_addr = '0;
    bridge_wr_data = '0;
    rom_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_range();
    test_clear();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_rom_loader.md
BRIDGE_ROM_LOADER -- requirements
Module: bridge_rom_loader

Interface
REQ-001 SHALL have parameter ROM_BYTES, default 32'h00100000, the ROM size in bytes; writes at or above this byte address are out of range.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of bridge words buffered; power of two, 2..16.
REQ-003 SHALL have port clk_74a, input, 1: the single clock; all logic is in this domain.
REQ-004 SHALL have port reset_n, input, 1: the reset, asynchronous and active-low.
REQ-005 SHALL have port bridge_wr, input, 1: one-cycle bridge write strobe.
REQ-006 SHALL have port bridge_rd, input, 1: one-cycle bridge read strobe.
REQ-007 SHALL have port bridge_addr, input, 32: bridge byte address, word aligned.
REQ-008 SHALL have port bridge_wr_data, input, 32: write word, big-endian, so bits [31:24] are the byte at bridge_addr+0.
REQ-009 SHALL have port bridge_rd_data, output, 32: read-back status word.
REQ-010 SHALL have port rom_wr, output, 1: byte write request to the ROM RAM.
REQ-011 SHALL have port rom_ready, input, 1: the ROM accepts the byte in any cycle where rom_wr and rom_ready are both high.
REQ-012 SHALL have port rom_addr, output, 20: ROM byte address.
REQ-013 SHALL have port rom_data, output, 8: ROM byte data.
REQ-014 SHALL have port busy, output, 1: high while the FIFO is non-empty or a word is being serialised.
REQ-015 SHALL have port overflow, output, 1: sticky flag set when a bridge write is dropped because the FIFO is full.
REQ-016 SHALL have port range_err, output, 1: sticky flag set when a bridge write is out of range.

Function
REQ-017 SHALL push {bridge_addr[19:2], bridge_wr_data} into the FIFO on bridge_wr when the address is in range and the FIFO is not full.
- Full: the write is dropped and overflow is set.
- Out of range: the write is dropped and range_err is set; the FIFO is untouched.
REQ-018 SHALL serialise each word with a two-state FSM, IDLE and SEND, plus a 2-bit byte index.
- IDLE -> SEND when the FIFO is non-empty: pop the word, index = 0.
- SEND: rom_wr = 1, rom_addr = {word_addr, index}, rom_data = the byte selected by index (index 0 is bits [31:24]).
REQ-019 SHALL advance the byte index only on rom_wr & rom_ready; rom_addr and rom_data SHALL hold stable while rom_ready is low.
REQ-020 SHALL, when index 3 is accepted, pop the next word and go directly to SEND (index 0) if the FIFO is non-empty, else return to IDLE, so back-to-back words have no bubble (4 bytes per 4 ready cycles).
REQ-021 SHALL allow a push and a pop in the same cycle while full; the pop frees the entry, so the push is accepted and overflow stays clear.
REQ-022 SHALL wrap FIFO pointers modulo FIFO_DEPTH and use an extra wrap bit to tell full from empty.
REQ-023 SHALL count accepted ROM bytes in a 21-bit counter that saturates at 21'h1FFFFF.
REQ-024 SHALL, on bridge_rd, register bridge_rd_data one cycle later as {busy, overflow, range_err, 8'd0, byte_count[20:0]}, regardless of bridge_addr; the value holds until the next bridge_rd.
REQ-025 SHALL clear overflow, range_err and byte_count on a bridge write with bridge_addr == ROM_BYTES-4 and data 32'hFFFFFFFF; that write is not pushed and does not set range_err.
REQ-026 SHALL keep bridge_wr and bridge_rd independent; both may occur in the same cycle.

Reset
REQ-027 SHALL, while reset_n is low, asynchronously force: FSM to IDLE, FIFO empty, rom_wr=0, rom_addr=0, rom_data=0, busy=0, overflow=0, range_err=0, byte_count=0, bridge_rd_data=0.
REQ-028 SHALL, if reset asserts mid-word, discard the partial word and all FIFO contents; no rom_wr is issued until a new write is pushed after reset release.

Verification
REQ-029 SHALL cover a single write: bridge_wr addr 0x100, data 0xA1B2C3D4, rom_ready=1 -> rom_wr for 4 cycles at addresses 0x100..0x103 with data A1, B2, C3, D4; byte_count=4.
REQ-030 SHALL cover backpressure: same write with rom_ready low for 3 cycles at byte 2 -> rom_addr=0x102, rom_data=C3 held stable for those cycles; no byte lost or duplicated.
REQ-031 SHALL cover overflow: 6 back-to-back writes, FIFO_DEPTH=4, rom_ready=0 -> words 1-4 buffered (FIFO full), words 5-6 dropped, overflow=1; after rom_ready=1, exactly 16 bytes are written.
REQ-032 SHALL cover range: write to addr 0x00100000 -> no rom_wr, range_err=1; a following bridge_rd returns bit 29 set.
REQ-033 SHALL cover reset mid-word: reset_n pulsed low after byte 1 with 2 words queued -> all outputs 0 immediately; no further rom_wr after release.
REQ-034 SHALL cover clear: after overflow is set, a write of 0xFFFFFFFF to 0x000FFFFC -> overflow=0, range_err=0, byte_count=0.
